// File: rtl/demux_1to8_deser.sv
// demux_1to8_deser: receive-side 1-to-8 serial demultiplexer.
// Each accepted serial bit lands in the shadow lane named by sel. A finished
// frame is copied to dout, so the next frame can be collected while dout waits
// for the consumer.
// Optional feature: define DEMUX_PARITY_EN to add a ninth (even-parity) bit
// per frame and drive parity_err. Without it, parity_err is tied low.
module demux_1to8_deser #(
    parameter int MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sel_clr,
    input  logic       dout_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic [2:0] sel,
    output logic       overrun,
    output logic       parity_err
);

    localparam bit REVERSE = (MSB_FIRST != 0);

`ifdef DEMUX_PARITY_EN
    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PARITY  = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_load_s;
    logic [7:0] frame_lanes_s;

    // Write one bit into the lane addressed by idx, leaving other lanes alone.
    function automatic logic [7:0] set_lane(input logic [7:0] lanes,
                                            input logic [2:0] idx,
                                            input logic       bit_in);
        logic [7:0] r;
        r      = lanes;
        r[idx] = bit_in;
        return r;
    endfunction

    // Map lane order onto dout bit order (lane k -> bit k, or bit 7-k).
    function automatic logic [7:0] lanes_to_dout(input logic [7:0] lanes);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (REVERSE) begin
                r[k] = lanes[7-k];
            end else begin
                r[k] = lanes[k];
            end
        end
        return r;
    endfunction

`ifdef DEMUX_PARITY_EN
    // Even parity over 8 data bits plus the received parity bit; 1 = error.
    function automatic logic parity9_err(input logic [7:0] data,
                                         input logic       par_bit);
        return (^data) ^ par_bit;
    endfunction
`endif

    // State register: realign/reset always return to COLLECT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: lane 7 leads to PARITY only when parity is compiled in.
    always_comb begin
        state_d = state_q;
        if (sel_clr) begin
            state_d = ST_COLLECT;
        end else if (din_valid) begin
            case (state_q)
                ST_COLLECT: begin
`ifdef DEMUX_PARITY_EN
                    if (sel_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_COLLECT;
                    end
`else
                    state_d = ST_COLLECT;
`endif
                end
`ifdef DEMUX_PARITY_EN
                ST_PARITY: state_d = ST_COLLECT;
`endif
                default:   state_d = ST_COLLECT;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: lane select/shadow updates and the frame-load strobe.
    always_comb begin
        sel_d         = sel_q;
        shadow_d      = shadow_q;
        frame_load_s  = 1'b0;
        frame_lanes_s = shadow_q;
        if (sel_clr) begin
            // Realign wins over a coincident data bit; the bit is dropped.
            sel_d    = 3'd0;
            shadow_d = 8'h00;
        end else if (din_valid) begin
            case (state_q)
                ST_COLLECT: begin
                    shadow_d = set_lane(shadow_q, sel_q, din);
`ifdef DEMUX_PARITY_EN
                    // sel parks at 7 while the parity bit is awaited.
                    if (sel_q == 3'd7) begin
                        sel_d = sel_q;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
`else
                    sel_d = sel_q + 3'd1;
                    if (sel_q == 3'd7) begin
                        frame_load_s  = 1'b1;
                        frame_lanes_s = shadow_d;
                    end else begin
                        frame_load_s  = 1'b0;
                    end
`endif
                end
`ifdef DEMUX_PARITY_EN
                ST_PARITY: begin
                    sel_d         = 3'd0;
                    frame_load_s  = 1'b1;
                    frame_lanes_s = shadow_q;
                end
`endif
                default: begin
                    sel_d    = 3'd0;
                    shadow_d = 8'h00;
                end
            endcase
        end else begin
            sel_d    = sel_q;
            shadow_d = shadow_q;
        end
    end

    // Output-side next values: load, valid handshake and overrun detection.
    always_comb begin
        if (frame_load_s) begin
            dout_d       = lanes_to_dout(frame_lanes_s);
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_d       = dout_q;
            dout_valid_d = 1'b0;
        end else begin
            dout_d       = dout_q;
            dout_valid_d = dout_valid_q;
        end
        overrun_d = frame_load_s & dout_valid_q & ~dout_ready;
    end

    // Datapath registers for the collector and the output frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= 3'd0;
            shadow_q     <= 8'h00;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef DEMUX_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Parity status changes only when a new frame lands in dout.
    always_comb begin
        if (frame_load_s) begin
            parity_err_d = parity9_err(shadow_q, din);
        end else begin
            parity_err_d = parity_err_q;
        end
    end

    // Parity status register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sel        = sel_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_demux_1to8_deser.sv
// Directed bench for demux_1to8_deser: LSB-first and MSB-first instances
// share the same stimulus. Works with or without DEMUX_PARITY_EN.
module tb_demux_1to8_deser;

`ifdef DEMUX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, din, din_valid, sel_clr, dout_ready;
    logic [7:0] dout, dout_m;
    logic       dout_valid, dout_valid_m;
    logic [2:0] sel, sel_m;
    logic       overrun, overrun_m;
    logic       parity_err, parity_err_m;

    int vectors    = 0;
    int miscompares = 0;

    demux_1to8_deser #(.MSB_FIRST(0)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .sel_clr(sel_clr), .dout_ready(dout_ready), .dout(dout),
        .dout_valid(dout_valid), .sel(sel), .overrun(overrun),
        .parity_err(parity_err)
    );

    demux_1to8_deser #(.MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .sel_clr(sel_clr), .dout_ready(dout_ready), .dout(dout_m),
        .dout_valid(dout_valid_m), .sel(sel_m), .overrun(overrun_m),
        .parity_err(parity_err_m)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one frame LSB-first (plus correct even parity when enabled);
    // dout_ready is raised only on the frame-completing edge if rdy_last.
    task automatic send_byte(input logic [7:0] data, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            din       = data[i];
            din_valid = 1'b1;
`ifndef DEMUX_PARITY_EN
            dout_ready = (i == 7) ? rdy_last : 1'b0;
`endif
            tick();
        end
`ifdef DEMUX_PARITY_EN
        din        = ^data;
        dout_ready = rdy_last;
        tick();
`endif
        din_valid  = 1'b0;
        din        = 1'b0;
        dout_ready = 1'b0;
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        vectors++;
        if (dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: dout_valid=%b expected 0", dout_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sel_clr = 1'b0; dout_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if ({dout, dout_valid, sel, overrun, parity_err} !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h",
                     {dout, dout_valid, sel, overrun, parity_err}, 14'h0000);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lsb_first();
        logic [7:0] data;
        logic [2:0] exp_sel;
        data = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            din = data[i]; din_valid = 1'b1;
            tick();
            exp_sel = (i == 7) ? (PAR_EN ? 3'd7 : 3'd0) : 3'(i + 1);
            vectors++;
            if (sel !== exp_sel) begin
                miscompares++;
                $display("FAIL lsb_sel bit%0d: sel=%0d expected %0d", i, sel, exp_sel);
            end
        end
`ifdef DEMUX_PARITY_EN
        din = ^data;
        tick();
`endif
        din_valid = 1'b0;
        vectors++;
        if ({dout, dout_valid, sel} !== {8'hA5, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL lsb_frame: dout=%h valid=%b sel=%0d expected a5 1 0", dout, dout_valid, sel);
        end
    endtask

    task automatic test_toggle_valid();
        logic [7:0] data;
        logic [2:0] exp_sel;
        data = 8'hA5;
        drain();
        for (int i = 0; i < 8; i++) begin
            din = data[i]; din_valid = 1'b1;
            tick();
            din = ~data[i]; din_valid = 1'b0;
            tick();
            exp_sel = (i == 7) ? (PAR_EN ? 3'd7 : 3'd0) : 3'(i + 1);
            vectors++;
            if (sel !== exp_sel) begin
                miscompares++;
                $display("FAIL toggle_hold bit%0d: sel=%0d expected %0d", i, sel, exp_sel);
            end
        end
`ifdef DEMUX_PARITY_EN
        din = ^data; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
`endif
        vectors++;
        if ({dout, dout_valid, sel} !== {8'hA5, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL toggle_frame: dout=%h valid=%b sel=%0d expected a5 1 0", dout, dout_valid, sel);
        end
    endtask

    task automatic test_overrun();
        drain();
        send_byte(8'h3C, 1'b0);
        vectors++;
        if ({dout, dout_valid, overrun} !== {8'h3C, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL ovr_first: dout=%h valid=%b ovr=%b expected 3c 1 0", dout, dout_valid, overrun);
        end
        send_byte(8'hC3, 1'b0);
        vectors++;
        if ({dout, dout_valid, overrun} !== {8'hC3, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL ovr_pulse: dout=%h valid=%b ovr=%b expected c3 1 1", dout, dout_valid, overrun);
        end
        tick();
        vectors++;
        if ({dout_valid, overrun} !== {1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL ovr_single: valid=%b ovr=%b expected 1 0", dout_valid, overrun);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b1);
        vectors++;
        if ({dout, dout_valid, overrun} !== {8'hAA, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_accept_load: dout=%h valid=%b ovr=%b expected aa 1 0", dout, dout_valid, overrun);
        end
        drain();
    endtask

    task automatic test_realign();
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 1'b1;
            tick();
        end
        sel_clr = 1'b1; din = 1'b1;
        tick();
        sel_clr = 1'b0; din_valid = 1'b0;
        vectors++;
        if ({sel, dout, dout_valid} !== {3'd0, 8'hAA, 1'b0}) begin
            miscompares++;
            $display("FAIL realign: sel=%0d dout=%h valid=%b expected 0 aa 0", sel, dout, dout_valid);
        end
        send_byte(8'hFF, 1'b0);
        vectors++;
        if ({dout, dout_valid, sel} !== {8'hFF, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL realign_frame: dout=%h valid=%b sel=%0d expected ff 1 0", dout, dout_valid, sel);
        end
        drain();
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({dout, dout_valid, sel} !== {8'h00, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL async_rst: dout=%h valid=%b sel=%0d expected 00 0 0", dout, dout_valid, sel);
        end
        #1;
        rst = 1'b0;
        send_byte(8'h81, 1'b0);
        vectors++;
        if ({dout, dout_valid, sel} !== {8'h81, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL rst_frame: dout=%h valid=%b sel=%0d expected 81 1 0", dout, dout_valid, sel);
        end
        drain();
    endtask

    task automatic test_msb_first();
        send_byte(8'h01, 1'b0);
        vectors++;
        if ({dout, dout_m} !== {8'h01, 8'h80}) begin
            miscompares++;
            $display("FAIL msb_lane0: dout=%h dout_m=%h expected 01 80", dout, dout_m);
        end
        drain();
        send_byte(8'h0F, 1'b0);
        vectors++;
        if ({dout, dout_m, sel_m} !== {8'h0F, 8'hF0, 3'd0}) begin
            miscompares++;
            $display("FAIL msb_0f: dout=%h dout_m=%h sel_m=%0d expected 0f f0 0", dout, dout_m, sel_m);
        end
        drain();
    endtask

    task automatic test_parity();
`ifdef DEMUX_PARITY_EN
        logic [7:0] data;
        logic       pbit;
        data = 8'h0F;
        for (int f = 0; f < 2; f++) begin
            pbit = (f == 0) ? 1'b1 : 1'b0;
            din_valid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                din = data[i];
                tick();
            end
            vectors++;
            if ({dout_valid, sel} !== {1'b0, 3'd7}) begin
                miscompares++;
                $display("FAIL par_wait%0d: valid=%b sel=%0d expected 0 7", f, dout_valid, sel);
            end
            din = pbit;
            tick();
            din_valid = 1'b0;
            vectors++;
            if ({dout, dout_valid, sel, parity_err} !== {8'h0F, 1'b1, 3'd0, pbit}) begin
                miscompares++;
                $display("FAIL par_frame%0d: dout=%h valid=%b sel=%0d perr=%b expected 0f 1 0 %b",
                         f, dout, dout_valid, sel, parity_err, pbit);
            end
            drain();
        end
`else
        send_byte(8'h0F, 1'b0);
        vectors++;
        if ({dout, dout_valid, parity_err} !== {8'h0F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL nopar_frame: dout=%h valid=%b perr=%b expected 0f 1 0", dout, dout_valid, parity_err);
        end
        drain();
`endif
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_toggle_valid();
        test_overrun();
        test_back_to_back();
        test_realign();
        test_msb_first();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
